// File: rtl/issue_scheduler.sv
// Instruction window with dependency table and round-robin issue selection.
// Each slot moves FREE -> WAIT (dispatch) -> ISSUED (issue handshake) -> FREE
// (completion). A slot's row holds the mask of slots it still waits on; a
// completion clears its column in every row.
module issue_scheduler #(
  parameter  int bs = 16,
  localparam int IW = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_valid,
  input  logic [bs-1:0] disp_dept,
  output logic          disp_ready,
  output logic [IW-1:0] disp_index,
  output logic          iss_valid,
  output logic [IW-1:0] iss_index,
  input  logic          iss_ready,
  input  logic          cmp_valid,
  input  logic [IW-1:0] cmp_index,
  output logic [bs-1:0] valid_entries,
  output logic [IW:0]   occupancy,
  output logic          err
);

  localparam logic [bs-1:0] ONE_HOT0 = {{(bs-1){1'b0}}, 1'b1};
  localparam int unsigned   BS_U     = bs;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_WAIT   = 2'd1,
    SLOT_ISSUED = 2'd2
  } slot_state_e;

  slot_state_e   slot_st [bs];
  logic [bs-1:0] dep_row [bs];
  logic [IW-1:0] rr_ptr;
  logic          lock;
  logic [IW-1:0] lock_idx;

  logic [bs-1:0] free_vec;
  logic [bs-1:0] issued_vec;
  logic [bs-1:0] elig_vec;
  logic          free_found;
  logic          cand_valid;
  logic [IW-1:0] cand_idx;
  logic [IW-1:0] scan_idx;
  logic          disp_fire;
  logic          iss_fire;
  logic          cmp_ok;
  logic          cmp_bad;
  logic [bs-1:0] cmp_mask;
  logic [bs-1:0] clr_mask;
  logic [bs-1:0] disp_row;

  // Per-slot status vectors and eligibility (waiting with an empty row)
  always_comb begin
    free_vec   = '0;
    issued_vec = '0;
    elig_vec   = '0;
    for (int unsigned k = 0; k < BS_U; k++) begin
      free_vec[k]   = (slot_st[k] == SLOT_FREE);
      issued_vec[k] = (slot_st[k] == SLOT_ISSUED);
      elig_vec[k]   = (slot_st[k] == SLOT_WAIT) && (dep_row[k] == '0);
    end
  end

  // Allocation view: lowest free slot, allocated mask and its population count
  always_comb begin
    disp_index = '0;
    free_found = 1'b0;
    occupancy  = '0;
    valid_entries = ~free_vec;
    for (int unsigned k = 0; k < BS_U; k++) begin
      if (!free_found && free_vec[k]) begin
        disp_index = IW'(k);
        free_found = 1'b1;
      end
      occupancy = occupancy + {{IW{1'b0}}, valid_entries[k]};
    end
    disp_ready = |free_vec;
  end

  // Round-robin pick: first eligible slot starting at rr_ptr, wrapping at bs
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < BS_U; i++) begin
      scan_idx = IW'((32'(rr_ptr) + i) % BS_U);
      if (!cand_valid && elig_vec[scan_idx]) begin
        cand_valid = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  // A locked candidate cannot lose eligibility: rows only shrink after
  // dispatch and only the issue handshake moves a slot out of WAIT.
  always_comb begin
    iss_valid = lock | cand_valid;
    iss_index = lock ? lock_idx : cand_idx;
  end

  // Handshakes and the masks applied to the dependency table
  always_comb begin
    disp_fire = disp_valid & disp_ready;
    iss_fire  = iss_valid & iss_ready;
    cmp_ok    = cmp_valid & issued_vec[cmp_index];
    cmp_bad   = cmp_valid & ~issued_vec[cmp_index];
    cmp_mask  = cmp_valid ? (ONE_HOT0 << cmp_index) : '0;
    clr_mask  = cmp_ok ? (ONE_HOT0 << cmp_index) : '0;
    disp_row  = disp_dept & valid_entries & ~(ONE_HOT0 << disp_index) & ~cmp_mask;
  end

  // Slot states and dependency rows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < BS_U; k++) begin
        slot_st[k] <= SLOT_FREE;
        dep_row[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < BS_U; k++) begin
        if (disp_fire && (disp_index == IW'(k))) begin
          slot_st[k] <= SLOT_WAIT;
          dep_row[k] <= disp_row;
        end else begin
          dep_row[k] <= dep_row[k] & ~clr_mask;
          if (iss_fire && (iss_index == IW'(k))) begin
            slot_st[k] <= SLOT_ISSUED;
          end else if (cmp_ok && (cmp_index == IW'(k))) begin
            slot_st[k] <= SLOT_FREE;
          end
        end
      end
    end
  end

  // Round-robin pointer, candidate lock and sticky completion error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err      <= 1'b0;
    end else begin
      if (iss_fire) begin
        rr_ptr <= (iss_index == IW'(bs - 1)) ? '0 : iss_index + 1'b1;
        lock   <= 1'b0;
      end else if (iss_valid) begin
        lock     <= 1'b1;
        lock_idx <= iss_index;
      end
      if (cmp_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule
